// File: rtl/mul_result_buffer.sv
// Tag pipe and result FIFO behind the pipelined multiplier. It stalls the multiplier when writeback backs up.
// Optional MUL_RESULT_BYPASS_EN: an empty FIFO shows a capture on wb_* in the same cycle.
module mul_result_buffer #(
  parameter int LATENCY = 3,
  parameter int DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   stall_in,
  input  logic                   issue_valid,
  input  logic [4:0]             issue_rd,
  output logic                   mul_stall,
  input  logic [31:0]            mul_ans,
  output logic                   wb_valid,
  input  logic                   wb_ready,
  output logic [4:0]             wb_rd,
  output logic [31:0]            wb_data,
  output logic [$clog2(DEPTH):0] count,
  input  logic [4:0]             rd_query,
  output logic                   rd_pending
);
  localparam int AW = $clog2(DEPTH);

  logic [LATENCY-1:0] tag_valid;
  logic [4:0]         tag_rd [LATENCY];
  logic [4:0]         fifo_rd [DEPTH];
  logic [31:0]        fifo_data [DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic               full, empty, capture, push, pop;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

  // A full FIFO always shows a valid head, so pop == wb_ready here.
  // This keeps wb_valid out of the stall path.
  assign mul_stall = stall_in | (full & ~wb_ready);

  assign capture = ~mul_stall & tag_valid[LATENCY-1] & (tag_rd[LATENCY-1] != 5'd0);

`ifdef MUL_RESULT_BYPASS_EN
  logic bypass;
  assign bypass   = empty & capture;
  assign wb_valid = ~empty | capture;
  assign wb_rd    = bypass ? tag_rd[LATENCY-1] : fifo_rd[rd_ptr];
  assign wb_data  = bypass ? mul_ans : fifo_data[rd_ptr];
  assign pop      = ~empty & wb_ready;
  assign push     = capture & ~(bypass & wb_ready);
`else
  assign wb_valid = ~empty;
  assign wb_rd    = fifo_rd[rd_ptr];
  assign wb_data  = fifo_data[rd_ptr];
  assign pop      = wb_valid & wb_ready;
  assign push     = capture;
`endif

  // The tag pipe moves in lockstep with the multiplier's own enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_valid <= '0;
    end else if (!mul_stall) begin
      tag_valid[0] <= issue_valid;
      for (int i = 1; i < LATENCY; i++) tag_valid[i] <= tag_valid[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!mul_stall) begin
      tag_rd[0] <= issue_rd;
      for (int i = 1; i < LATENCY; i++) tag_rd[i] <= tag_rd[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= tag_rd[LATENCY-1];
      fifo_data[wr_ptr] <= mul_ans;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  logic hit;
  always_comb begin
    hit = issue_valid & (issue_rd == rd_query);
    for (int i = 0; i < LATENCY; i++)
      hit = hit | (tag_valid[i] & (tag_rd[i] == rd_query));
    for (int i = 0; i < DEPTH; i++)
      if ((AW+1)'(i) < count)
        hit = hit | (fifo_rd[rd_ptr + AW'(i)] == rd_query);
    rd_pending = hit & (rd_query != 5'd0);
  end

endmodule

// File: tb/tb_mul_result_buffer.sv
// Directed bench for mul_result_buffer. It includes a behavioural 3-stage multiplier and a writeback scoreboard.
module tb_mul_result_buffer;
`ifdef MUL_RESULT_BYPASS_EN
  localparam int WB_LAT = 3;
`else
  localparam int WB_LAT = 4;
`endif

  logic        clk = 1'b0;
  logic        rst_n, stall_in, issue_valid, mul_stall, wb_valid, wb_ready, rd_pending;
  logic [4:0]  issue_rd, wb_rd, rd_query;
  logic [31:0] mul_ans, wb_data, op_a, op_b;
  logic [2:0]  count;
  logic [31:0] mp [3];

  typedef struct packed {logic [4:0] rd; logic [31:0] dat;} exp_t;
  exp_t exp_q[$];

  int n_checks = 0, n_pass = 0, n_fail = 0, n_hs = 0;

  mul_result_buffer #(.LATENCY(3), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .stall_in(stall_in), .issue_valid(issue_valid),
    .issue_rd(issue_rd), .mul_stall(mul_stall), .mul_ans(mul_ans),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .count(count), .rd_query(rd_query), .rd_pending(rd_pending)
  );

  always #5 clk = ~clk;

  // Multiplier stand-in: no reset, advances only when not stalled.
  always @(posedge clk) begin
    if (!mul_stall) begin
      mp[0] <= op_a * op_b;
      mp[1] <= mp[0];
      mp[2] <= mp[1];
    end
  end
  assign mul_ans = mp[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard and hold-stability monitor.
  logic        hold_prev = 1'b0;
  logic [4:0]  prev_rd;
  logic [31:0] prev_data;
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (wb_valid && wb_ready) begin
        n_hs++;
        chk("wb_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("wb_rd", 32'(wb_rd), 32'(e.rd));
          chk("wb_data", wb_data, e.dat);
        end
      end
      if (hold_prev) begin
        chk("hold_valid", 32'(wb_valid), 32'd1);
        chk("hold_rd", 32'(wb_rd), 32'(prev_rd));
        chk("hold_data", wb_data, prev_data);
      end
      hold_prev = wb_valid && !wb_ready;
      prev_rd   = wb_rd;
      prev_data = wb_data;
      if (issue_valid && !mul_stall && issue_rd != 5'd0)
        exp_q.push_back({issue_rd, op_a * op_b});
    end else begin
      hold_prev = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_issue(input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b);
    int w;
    issue_valid = 1'b1; issue_rd = rd; op_a = a; op_b = b;
    w = 0;
    @(negedge clk);
    while (mul_stall && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("issue_accept", 32'(mul_stall), 32'd0);
    tick();
    issue_valid = 1'b0;
  endtask

  initial begin
    int base, maxc, w;
    logic popped, done;
    rst_n = 1'b0; stall_in = 1'b0; issue_valid = 1'b0; issue_rd = '0;
    wb_ready = 1'b0; rd_query = 5'd5; op_a = '0; op_b = '0;

    // Reset values
    tick(); tick();
    stall_in = 1'b1;
    @(negedge clk);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_pending", 32'(rd_pending), 32'd0);
    chk("rst_stall_hi", 32'(mul_stall), 32'd1);
    stall_in = 1'b0;
    #1 chk("rst_stall_lo", 32'(mul_stall), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Single multiply, fixed latency, one-cycle valid
    wb_ready = 1'b1;
    do_issue(5'd5, 32'd7, 32'd6);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      chk($sformatf("single_valid_c%0d", c), 32'(wb_valid), 32'(c == WB_LAT));
    end
    tick();

    // Back-pressure: six issues into a four-entry FIFO
    wb_ready = 1'b0;
    base = n_hs;
    for (int i = 1; i <= 6; i++) do_issue(5'(i), 32'(i), 32'(i + 10));
    maxc = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (int'(count) > maxc) maxc = int'(count);
    end
    chk("bp_count_full", 32'(count), 32'd4);
    chk("bp_stall", 32'(mul_stall), 32'd1);
    chk("bp_max_count", 32'(maxc), 32'd4);
    tick();
    wb_ready = 1'b1;
    w = 0;
    while (n_hs - base < 6 && w < 40) begin tick(); w++; end
    repeat (3) tick();
    @(negedge clk);
    chk("bp_drained", 32'(n_hs - base), 32'd6);
    chk("bp_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("bp_count_zero", 32'(count), 32'd0);
    tick();

    // rd=0 discard; a zero query never reports pending
    base = n_hs; rd_query = 5'd0; maxc = 0;
    do_issue(5'd0, 32'd3, 32'd3);
    do_issue(5'd3, 32'd4, 32'd5);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("q0_pending", 32'(rd_pending), 32'd0);
      if (int'(count) > maxc) maxc = int'(count);
    end
    chk("disc_hs", 32'(n_hs - base), 32'd1);
    chk("disc_maxcnt_le1", 32'(maxc <= 1), 32'd1);
    tick();

    // stall_in for five cycles with two multiplies in flight
    base = n_hs;
    do_issue(5'd7, 32'd2, 32'd3);
    do_issue(5'd8, 32'd4, 32'd5);
    stall_in = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall_mul_stall", 32'(mul_stall), 32'd1);
      chk("stall_no_wb", 32'(wb_valid), 32'd0);
      tick();
    end
    stall_in = 1'b0;
    w = 0;
    while (n_hs - base < 2 && w < 20) begin tick(); w++; end
    repeat (2) tick();
    chk("stall_hs", 32'(n_hs - base), 32'd2);

    // rd_pending over the life of one result
    rd_query = 5'd9;
    @(negedge clk);
    chk("pend_before", 32'(rd_pending), 32'd0);
    tick();
    issue_valid = 1'b1; issue_rd = 5'd9; op_a = 32'd9; op_b = 32'd9;
    @(negedge clk);
    chk("pend_issue_cycle", 32'(rd_pending), 32'd1);
    tick();
    issue_valid = 1'b0;
    popped = 1'b0; done = 1'b0;
    for (int c = 0; c < 12 && !done; c++) begin
      @(negedge clk);
      if (popped) begin
        chk("pend_after_pop", 32'(rd_pending), 32'd0);
        done = 1'b1;
      end else begin
        chk("pend_inflight", 32'(rd_pending), 32'd1);
        popped = wb_valid && wb_ready;
      end
    end
    chk("pend_pop_seen", 32'(done), 32'd1);
    tick();

    // Asynchronous reset with three buffered and two in flight
    wb_ready = 1'b0; rd_query = 5'd14;
    for (int i = 11; i <= 15; i++) do_issue(5'(i), 32'(i), 32'd2);
    w = 0;
    @(negedge clk);
    while (count != 3'd3 && w < 20) begin @(negedge clk); w++; end
    chk("rst_mid_buffered", 32'(count), 32'd3);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_mid_count", 32'(count), 32'd0);
    chk("rst_mid_pending", 32'(rd_pending), 32'd0);
    exp_q.delete();
    tick();
    issue_valid = 1'b1; issue_rd = 5'd20; op_a = 32'd5; op_b = 32'd5;
    @(posedge clk); #1;
    rst_n = 1'b1; issue_valid = 1'b0; wb_ready = 1'b1; rd_query = 5'd20;
    base = n_hs;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk("post_rst_no_wb", 32'(wb_valid), 32'd0);
      chk("post_rst_count", 32'(count), 32'd0);
    end
    chk("post_rst_hs", 32'(n_hs - base), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
